axil_arbiter_rr_wr: RTL and testbench
=====================================

// Module: axil_arbiter_rr_wr
// PURPOSE
//  Per-slave write-channel arbiter for the AXI-Lite interconnect: round-robin alternative to the fixed-priority arbiter.
//  One instance per slave port; grants one master the AW/W/B path to that slave for one whole write transaction.
//  Lock is held from grant until the B handshake, so AW, W and B of a transaction never interleave between masters.
//  Drives the crossbar grant_wr / grant_wr_cdr inputs; optional watchdog flags a hung slave.
// PARAMETERS
//  NUMBER_MASTER   2   masters competing for this slave; legal range 2..16
//  TIMEOUT_CYCLES  0   watchdog limit in cycles from grant to B handshake; 0 = watchdog disabled
// PORTS
//  aclk            in   1                        clock; all logic on rising edge
//  aresetn         in   1                        reset, asynchronous assert, active-low
//  request_wr      in   NUMBER_MASTER            per-master request (decoded awvalid|wvalid hitting this slave)
//  s_axil_awvalid  in   1                        slave-side AW valid (crossbar output)
//  s_axil_awready  in   1                        slave-side AW ready
//  s_axil_wvalid   in   1                        slave-side W valid
//  s_axil_wready   in   1                        slave-side W ready
//  s_axil_bvalid   in   1                        slave B valid
//  m_axil_bready   in   NUMBER_MASTER            bready of every master
//  grant_wr        out  NUMBER_MASTER            one-hot grant, all-zero when idle
//  grant_wr_cdr    out  $clog2(NUMBER_MASTER)    binary index of granted master; 0 when idle
//  busy            out  1                        high in GRANT or RESP
//  err_timeout     out  1                        single-cycle pulse on watchdog expiry
// BEHAVIOUR
//  Reset (aresetn=0, async): state=IDLE, grant_wr=0, grant_wr_cdr=0, busy=0, err_timeout=0, rr_ptr=0, aw_done=w_done=0, wdog=0.
//  All outputs registered.
//  States:
//   IDLE : grant_wr=0. If |request_wr: winner = first set bit scanning rr_ptr, rr_ptr+1, ... mod NUMBER_MASTER.
//          Register the one-hot grant and index -> GRANT. Grant is visible 1 cycle after the request is sampled.
//   GRANT: grant frozen. aw_done set on awvalid&awready; w_done set on wvalid&wready.
//          Handshakes may occur in the same cycle or in either order.
//          When (aw_done|aw_hs) & (w_done|w_hs) -> RESP, same edge that records the last handshake.
//   RESP : wait s_axil_bvalid & m_axil_bready[grant_wr_cdr] -> IDLE.
//          On that edge: grant_wr<=0, rr_ptr<=(grant_wr_cdr+1) mod NUMBER_MASTER (wrap N-1 -> 0), aw_done=w_done=0.
//  Minimum one IDLE cycle between transactions; back-to-back grants are therefore 1 dead cycle apart.
//  Requests dropping or changing while busy are ignored; grant never changes before the B handshake.
//  bready of non-granted masters is ignored.
//  Fairness: a continuously requesting master waits at most NUMBER_MASTER-1 transactions.
//  Watchdog (TIMEOUT_CYCLES>0):
//   - wdog counts cycles in GRANT|RESP and clears in IDLE.
//   - Pulse err_timeout once when wdog==TIMEOUT_CYCLES-1; wdog saturates, so no repeated pulses.
//   - State is unaffected; the lock persists until the B handshake or reset.
//  TIMEOUT_CYCLES=0: err_timeout tied 0, counter removed.
//  Reset mid-transaction: immediate return to reset values; any half-done AW/W is abandoned.
//  No state is retained.
// STRUCTURE
//  Package axil_ic_pkg:
//   - typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_RESP} axil_arb_state_t;
//   - AXIL_RESP_OKAY/SLVERR constants; function onehot_to_bin.
//  Sub-module axil_rr_pick: combinational rotating-priority picker (req, ptr -> onehot, index, any).
//  Double-width request vector with masked scan.
//  FSM, done flags, rr_ptr and watchdog live in the top.
// TESTING (NUMBER_MASTER=4, TIMEOUT_CYCLES=16)
//  1. request_wr=4'b0100 from IDLE; AW+W same cycle; B after 2 cycles
//     -> grant_wr=4'b0100 and cdr=2 next cycle; RESP; grant=0 after B; rr_ptr=3.
//  2. request_wr=4'b1111 held for 8 transactions from reset -> grant order 0,1,2,3,0,1,2,3; each grant preceded by 1 idle cycle.
//  3. Granted master 1; W handshake 3 cycles before AW; requester 0 asserts meanwhile
//     -> grant stays 4'b0010 until B with m_axil_bready[1]=1; bready[0]=1 alone does not release.
//  4. rr_ptr=3, request_wr=4'b1001 -> grant master 3; next round grant master 0 (wrap-around).
//  5. Slave never asserts bvalid -> err_timeout pulses exactly once, 16 cycles after grant; busy stays 1.
//  6. aresetn low during RESP -> grant_wr=0, busy=0 same cycle (async); after release, request 4'b0010 -> grant master 1.

Source files
------------

// File: rtl/axil_ic_pkg.sv
// Shared types, constants and helpers for the AXI-Lite interconnect arbiters.
package axil_ic_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_RESP  = 2'd2
  } axil_arb_state_t;

  localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;

  // Encodes a one-hot vector of up to 16 masters into its binary index.
  function automatic logic [3:0] onehot_to_bin(input logic [15:0] onehot);
    logic [3:0] bin;
    bin = '0;
    for (int i = 0; i < 16; i++) begin
      if (onehot[i]) bin = bin | 4'(i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/axil_rr_pick.sv
// Rotating-priority picker: first set request at or after ptr_i, wrapping around.
module axil_rr_pick
  import axil_ic_pkg::*;
#(
  parameter  int N     = 2,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     onehot_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic [2*N-1:0] req2;
  logic [2*N-1:0] masked;
  logic [2*N-1:0] first;

  // The upper copy of the requests supplies the wrapped-around candidates
  // below ptr_i, so the lowest set bit of the masked vector is the winner.
  always_comb begin
    req2     = {req_i, req_i};
    masked   = req2 & ({(2*N){1'b1}} << ptr_i);
    first    = masked & (-masked);
    onehot_o = first[N-1:0] | first[2*N-1:N];
    idx_o    = IDX_W'(onehot_to_bin(16'(onehot_o)));
    any_o    = |req_i;
  end

endmodule

// File: rtl/axil_arbiter_rr_wr.sv
// Per-slave round-robin write arbiter: locks one master onto AW/W/B from grant to B handshake.
module axil_arbiter_rr_wr
  import axil_ic_pkg::*;
#(
  parameter int NUMBER_MASTER  = 2,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic [NUMBER_MASTER-1:0]         request_wr,
  input  logic                             s_axil_awvalid,
  input  logic                             s_axil_awready,
  input  logic                             s_axil_wvalid,
  input  logic                             s_axil_wready,
  input  logic                             s_axil_bvalid,
  input  logic [NUMBER_MASTER-1:0]         m_axil_bready,
  output logic [NUMBER_MASTER-1:0]         grant_wr,
  output logic [$clog2(NUMBER_MASTER)-1:0] grant_wr_cdr,
  output logic                             busy,
  output logic                             err_timeout
);

  localparam int               IDX_W    = $clog2(NUMBER_MASTER);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUMBER_MASTER - 1);

  axil_arb_state_t            state_q, state_d;
  logic [NUMBER_MASTER-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]           cdr_q, cdr_d;
  logic [IDX_W-1:0]           rr_ptr_q, rr_ptr_d;
  logic                       busy_q, busy_d;
  logic                       aw_done_q, aw_done_d;
  logic                       w_done_q, w_done_d;

  logic [NUMBER_MASTER-1:0]   pick_onehot;
  logic [IDX_W-1:0]           pick_idx;
  logic                       pick_any;
  logic                       aw_hs, w_hs, b_hs;

  axil_rr_pick #(.N(NUMBER_MASTER)) u_pick (
    .req_i    (request_wr),
    .ptr_i    (rr_ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  assign aw_hs = s_axil_awvalid & s_axil_awready;
  assign w_hs  = s_axil_wvalid & s_axil_wready;
  // Only the locked master's bready can complete the response.
  assign b_hs  = s_axil_bvalid & m_axil_bready[cdr_q];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= ARB_IDLE;
      grant_q   <= '0;
      cdr_q     <= '0;
      rr_ptr_q  <= '0;
      busy_q    <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      cdr_q     <= cdr_d;
      rr_ptr_q  <= rr_ptr_d;
      busy_q    <= busy_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE:  if (pick_any) state_d = ARB_GRANT;
      ARB_GRANT: if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) state_d = ARB_RESP;
      ARB_RESP:  if (b_hs) state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    grant_d   = grant_q;
    cdr_d     = cdr_q;
    rr_ptr_d  = rr_ptr_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    unique case (state_q)
      ARB_IDLE: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (pick_any) begin
          grant_d = pick_onehot;
          cdr_d   = pick_idx;
        end
      end
      ARB_GRANT: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
      end
      ARB_RESP: begin
        if (b_hs) begin
          grant_d   = '0;
          cdr_d     = '0;
          rr_ptr_d  = (cdr_q == LAST_IDX) ? '0 : cdr_q + IDX_W'(1);
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      default: begin
        grant_d = '0;
        cdr_d   = '0;
      end
    endcase
    busy_d = (state_d != ARB_IDLE);
  end

  assign grant_wr     = grant_q;
  assign grant_wr_cdr = cdr_q;
  assign busy         = busy_q;

  // The watchdog saturates one past the firing value so it pulses only once per lock.
  if (TIMEOUT_CYCLES > 0) begin : g_wdog
    localparam int                WDOG_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WDOG_W-1:0] WDOG_MAX  = WDOG_W'(TIMEOUT_CYCLES);
    localparam logic [WDOG_W-1:0] WDOG_FIRE = WDOG_W'(TIMEOUT_CYCLES - 1);

    logic [WDOG_W-1:0] wdog_q;
    logic              err_q;

    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        wdog_q <= '0;
        err_q  <= 1'b0;
      end else begin
        if (state_q == ARB_IDLE)   wdog_q <= '0;
        else if (wdog_q != WDOG_MAX) wdog_q <= wdog_q + WDOG_W'(1);
        err_q <= (state_q != ARB_IDLE) && (wdog_q == WDOG_FIRE);
      end
    end

    assign err_timeout = err_q;
  end else begin : g_no_wdog
    assign err_timeout = 1'b0;
  end

endmodule

// File: tb/tb_axil_arbiter_rr_wr.sv
// Randomized self-checking bench for axil_arbiter_rr_wr against a round-robin reference model.
module tb_axil_arbiter_rr_wr;

  localparam int NM      = 4;
  localparam int TIMEOUT = 16;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [NM-1:0] request_wr = '0;
  logic          s_axil_awvalid = 1'b0;
  logic          s_axil_awready = 1'b0;
  logic          s_axil_wvalid = 1'b0;
  logic          s_axil_wready = 1'b0;
  logic          s_axil_bvalid = 1'b0;
  logic [NM-1:0] m_axil_bready = '0;
  logic [NM-1:0] grant_wr;
  logic [1:0]    grant_wr_cdr;
  logic          busy;
  logic          err_timeout;

  int n_checks = 0;
  int n_errors = 0;
  int ref_ptr  = 0;

  int         w_s;
  logic [3:0] oh_s;
  int         n_s;
  int         pulses;

  axil_arbiter_rr_wr #(.NUMBER_MASTER(NM), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .request_wr     (request_wr),
    .s_axil_awvalid (s_axil_awvalid),
    .s_axil_awready (s_axil_awready),
    .s_axil_wvalid  (s_axil_wvalid),
    .s_axil_wready  (s_axil_wready),
    .s_axil_bvalid  (s_axil_bvalid),
    .m_axil_bready  (m_axil_bready),
    .grant_wr       (grant_wr),
    .grant_wr_cdr   (grant_wr_cdr),
    .busy           (busy),
    .err_timeout    (err_timeout)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge aclk);
  endtask

  // Reference: scan masters ref_ptr, ref_ptr+1, ... modulo NM for the first requester.
  function automatic int model_pick(input logic [3:0] req);
    int m;
    for (int k = 0; k < NM; k++) begin
      m = (ref_ptr + k) % NM;
      if (req[m]) return m;
    end
    return -1;
  endfunction

  task automatic apply_reset();
    aresetn = 1'b0;
    request_wr = '0;
    s_axil_awvalid = 1'b0; s_axil_awready = 1'b0;
    s_axil_wvalid = 1'b0;  s_axil_wready = 1'b0;
    s_axil_bvalid = 1'b0;  m_axil_bready = '0;
    repeat (3) tick();
    check("rst_grant", 32'(grant_wr), 0);
    check("rst_cdr", 32'(grant_wr_cdr), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(err_timeout), 0);
    aresetn = 1'b1;
    ref_ptr = 0;
    tick();
  endtask

  task automatic check_locked(input string tag, input logic [3:0] oh, input int w, input int n);
    check({tag, "_grant"}, 32'(grant_wr), 32'(oh));
    check({tag, "_cdr"}, 32'(grant_wr_cdr), 32'(w));
    check({tag, "_busy"}, 32'(busy), 1);
    check({tag, "_err"}, 32'(err_timeout), 32'(n == TIMEOUT));
  endtask

  // One full write transaction; handshakes at chosen cycle offsets, B after b_dly stalled cycles.
  task automatic do_txn(input logic [3:0] req, input int aw_dly, input int w_dly, input int b_dly);
    int w;
    int n;
    int last;
    logic [3:0] oh;
    check("idle_grant", 32'(grant_wr), 0);
    check("idle_busy", 32'(busy), 0);
    w  = model_pick(req);
    oh = 4'(1 << w);
    request_wr = req;
    tick();
    n = 0;
    check_locked("grant", oh, w, n);
    last = (aw_dly > w_dly) ? aw_dly : w_dly;
    for (int c = 0; c <= last; c++) begin
      request_wr     = 4'($urandom);
      s_axil_awready = (c == aw_dly);
      s_axil_awvalid = (c == aw_dly) | 1'($urandom);
      s_axil_wready  = (c == w_dly);
      s_axil_wvalid  = (c == w_dly) | 1'($urandom);
      tick();
      n++;
      check_locked("hs", oh, w, n);
    end
    s_axil_awvalid = 1'b0; s_axil_awready = 1'b0;
    s_axil_wvalid  = 1'b0; s_axil_wready  = 1'b0;
    for (int k = 0; k < b_dly; k++) begin
      if (k == 0) begin
        s_axil_bvalid = 1'b1;
        m_axil_bready = ~oh;
      end else begin
        s_axil_bvalid = 1'($urandom);
        m_axil_bready = s_axil_bvalid ? (4'($urandom) & ~oh) : 4'($urandom);
      end
      request_wr = 4'($urandom);
      tick();
      n++;
      check_locked("bwait", oh, w, n);
    end
    s_axil_bvalid = 1'b1;
    m_axil_bready = 4'($urandom) | oh;
    request_wr    = req;
    tick();
    check("rel_grant", 32'(grant_wr), 0);
    check("rel_cdr", 32'(grant_wr_cdr), 0);
    check("rel_busy", 32'(busy), 0);
    check("rel_err", 32'(err_timeout), 0);
    s_axil_bvalid = 1'b0;
    m_axil_bready = '0;
    ref_ptr = (w + 1) % NM;
  endtask

  initial begin
    tick();
    apply_reset();

    // Single requester, AW+W together, B two cycles later; leaves pointer at 3.
    do_txn(4'b0100, 0, 0, 2);
    // Pointer at 3 with masters 0 and 3 requesting: 3 first, then wrap to 0.
    do_txn(4'b1001, 1, 0, 1);
    do_txn(4'b1001, 0, 2, 3);
    // W three cycles before AW on master 1 while others request.
    do_txn(4'b0010, 3, 0, 2);

    // All masters requesting from reset: strict rotation 0,1,2,3,0,1,2,3.
    apply_reset();
    for (int t = 0; t < 8; t++) begin
      check("rot_order", 32'(model_pick(4'b1111)), 32'(t % NM));
      do_txn(4'b1111, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(1, 3));
    end

    for (int t = 0; t < 40; t++)
      do_txn(4'($urandom_range(1, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(1, 4));

    // Hung slave: no B, watchdog fires once, lock persists.
    check("wd_idle", 32'(busy), 0);
    w_s  = model_pick(4'b0001);
    oh_s = 4'(1 << w_s);
    request_wr = 4'b0001;
    tick();
    n_s = 0;
    check_locked("wd_grant", oh_s, w_s, n_s);
    s_axil_awvalid = 1'b1; s_axil_awready = 1'b1;
    s_axil_wvalid  = 1'b1; s_axil_wready  = 1'b1;
    request_wr = 4'b1111;
    tick();
    n_s++;
    s_axil_awvalid = 1'b0; s_axil_awready = 1'b0;
    s_axil_wvalid  = 1'b0; s_axil_wready  = 1'b0;
    pulses = 0;
    while (n_s < 2 * TIMEOUT) begin
      check_locked("wd_hold", oh_s, w_s, n_s);
      if (err_timeout) pulses++;
      tick();
      n_s++;
    end
    check("wd_pulses", 32'(pulses), 1);
    s_axil_bvalid = 1'b1;
    m_axil_bready = oh_s;
    tick();
    check("wd_rel_grant", 32'(grant_wr), 0);
    check("wd_rel_busy", 32'(busy), 0);
    check("wd_rel_err", 32'(err_timeout), 0);
    s_axil_bvalid = 1'b0;
    m_axil_bready = '0;
    ref_ptr = (w_s + 1) % NM;

    // Asynchronous reset while waiting for B.
    w_s  = model_pick(4'b1000);
    oh_s = 4'(1 << w_s);
    request_wr = 4'b1000;
    tick();
    check_locked("ar_grant", oh_s, w_s, 0);
    s_axil_awvalid = 1'b1; s_axil_awready = 1'b1;
    s_axil_wvalid  = 1'b1; s_axil_wready  = 1'b1;
    tick();
    s_axil_awvalid = 1'b0; s_axil_awready = 1'b0;
    s_axil_wvalid  = 1'b0; s_axil_wready  = 1'b0;
    check_locked("ar_resp", oh_s, w_s, 1);
    #2 aresetn = 1'b0;
    #1;
    check("ar_grant0", 32'(grant_wr), 0);
    check("ar_busy0", 32'(busy), 0);
    check("ar_cdr0", 32'(grant_wr_cdr), 0);
    tick();
    aresetn = 1'b1;
    request_wr = '0;
    ref_ptr = 0;
    tick();
    check("ar_post_pick", 32'(model_pick(4'b0010)), 1);
    do_txn(4'b0010, 0, 1, 1);
    do_txn(4'b1111, 1, 1, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
